fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
Instruction-fetch front end: the consumer of branch_flush/branch_pc produced in the execute stage.
- Owns the architectural fetch PC and issues word requests to instruction memory over a req/gnt + rvalid protocol.
- Buffers returned instructions toward decode through a valid/ready interface.
- On a redirect: re-steers the PC, kills buffered instructions, and silently discards in-flight responses from the wrong path.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries; also the max in-flight requests (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
branch_flush  in  1  redirect request from execute
branch_pc  in  32  redirect target
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid, in request order
imem_rdata  in  32  response instruction
if_valid  out  1  instruction available to decode
if_instr  out  32  instruction
if_pc  out  32  PC of if_instr
id_ready  in  1  decode accepts

Behaviour:
Reset (async assert, sync release):
- pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=BOOT.
- imem_req=0, if_valid=0.

FSM:
- BOOT: one cycle, no request, then -> RUN.
- RUN -> DRAIN when a flush leaves discard>0.
- DRAIN -> RUN when discard reaches 0.
- A flush in DRAIN re-arms discard.
- Requests may issue in both RUN and DRAIN.

Credit rule:
- imem_req=1 iff state!=BOOT and (outstanding + fifo_count) < FIFO_DEPTH, both evaluated after any same-cycle flush clear.
- Responses therefore always have FIFO space; no backpressure on rvalid.

Addressing:
- imem_addr = branch_flush ? {branch_pc[31:2],2'b00} : pc.
- Redirect is zero-bubble; the combinational flush->addr path is intended.
- An ungranted request may change address or drop; a granted one may not be retracted.

On imem_gnt:
- pc <= imem_addr+4, wrapping mod 2^32.
- outstanding++.

On imem_rvalid:
- outstanding--.
- If discard>0 (or flush this cycle): drop it, discard-- when applicable.
- Else push {rdata, tag pc} into the FIFO.
- The tag PC comes from a parallel in-order address queue of depth FIFO_DEPTH.

Flush cycle:
- FIFO and address queue cleared; if_valid forced 0.
- discard <= outstanding, minus 1 if rvalid this cycle.
- A gnt in the same cycle belongs to the new path and is not discarded.

Decode side:
- if_valid = !fifo_empty & !branch_flush.
- Pop on if_valid & id_ready.
- if_instr/if_pc hold stable while if_valid & !id_ready.
- Push and pop in the same cycle are allowed at full/empty.

Latency:
- Minimum 2 cycles from gnt to if_valid, with the memory answering rvalid the cycle after gnt.
- Sustained throughput 1 instr/cycle with a 1-cycle memory and FIFO_DEPTH=2.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: adds outputs redirect_cnt[31:0] (increments per branch_flush cycle) and discard_cnt[31:0] (increments per dropped response). Both reset to 0 and wrap.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- rtl/parameters.vh: FSM state encodings BOOT/RUN/DRAIN and the default RESET_PC.
- Sub-module fetch_fifo: synchronous FIFO (width, depth params) with a flush input. Instantiated twice: instruction data and address tag.

Test Plan:
1. Reset release with 1-cycle memory, id_ready=1 -> no req in first cycle. Then addrs 0x0,0x4,0x8 issued back-to-back; if_pc 0x0 appears 2 cycles after first gnt, one instr/cycle thereafter.
2. id_ready=0 for 5 cycles -> req deasserts once outstanding+count=2; if_instr/if_pc stable; no lost or duplicated instr on release.
3. branch_flush with branch_pc=0x100 while 2 requests in flight -> imem_addr=0x100 that cycle. Next two rvalids dropped; first if_pc=0x100 then 0x104; state returns to RUN.
4. branch_flush coincident with rvalid and gnt -> that rvalid dropped, discard=outstanding-1; granted 0x200 request delivered.
5. branch_pc=0x103 -> fetch at 0x100; pc=0xFFFF_FFFC then gnt -> next addr 0x0.
6. rst_n asserted mid-DRAIN -> outputs immediately 0; after release, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared constants for the instruction-fetch front end: FSM encodings, default
// reset PC and the word-alignment helper used on redirect targets.
package fetch_redirect_unit_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with a single-cycle flush. A push in the
// flush cycle survives and becomes the only entry.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, waddr;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop, empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign waddr = flush ? '0 : wptr_q;

  // Push into a full FIFO is legal only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop & ~empty & ~flush;
    do_push = push & (~full | do_pop | flush);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = do_push ? PW'(1) : '0;
      count_d = do_push ? (PW+1)'(1) : '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[waddr] <= wdata;
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited imem requests and
// drops wrong-path responses after a redirect. FETCH_PERF_CNT_EN adds counters.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_flush,
  input  logic [31:0] branch_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] discard_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [CW-1:0] buf_count, tag_count, eff_count;
  logic [CW:0]   credit_used;
  logic [63:0]   buf_rdata;
  logic [31:0]   tag_rdata;
  logic          gnt, pop, drop, accept;

  assign imem_addr = branch_flush ? word_align(branch_pc) : pc_q;
  assign if_valid  = (buf_count != '0) & ~branch_flush;
  assign if_instr  = buf_rdata[63:32];
  assign if_pc     = buf_rdata[31:0];
  assign pop       = if_valid & id_ready;
  assign gnt       = imem_req & imem_gnt;
  assign drop      = imem_rvalid & (branch_flush | (discard_q != '0));
  assign accept    = imem_rvalid & ~drop & (tag_count != '0);

  // A slot freed by a same-cycle pop is reusable at once; this is what keeps
  // a 1-cycle memory streaming one instruction per cycle with two entries.
  assign eff_count   = branch_flush ? '0 : buf_count - CW'(pop);
  assign credit_used = {1'b0, outst_q} + {1'b0, eff_count};
  assign imem_req    = (state_q != ST_BOOT) & (credit_used < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    pc_d = pc_q;
    if (gnt) pc_d = imem_addr + 32'd4;
    else if (branch_flush) pc_d = imem_addr;

    outst_d = outst_q + CW'(gnt) - CW'(imem_rvalid);

    // Everything in flight at the redirect is wrong-path, except a response
    // landing this very cycle, which is dropped immediately.
    discard_d = discard_q;
    if (branch_flush) discard_d = outst_q - CW'(imem_rvalid);
    else if (drop) discard_d = discard_q - CW'(1);

    if (state_q == ST_BOOT) state_d = ST_RUN;
    else state_d = (discard_d != '0) ? ST_DRAIN : ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  // Address tags of granted requests, consumed in order by accepted responses.
  fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (branch_flush),
    .push  (gnt),
    .wdata (imem_addr),
    .pop   (accept),
    .rdata (tag_rdata),
    .count (tag_count)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (branch_flush),
    .push  (accept),
    .wdata ({imem_rdata, tag_rdata}),
    .pop   (pop),
    .rdata (buf_rdata),
    .count (buf_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d, discard_cnt_q, discard_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q + {31'd0, branch_flush};
    discard_cnt_d  = discard_cnt_q + {31'd0, drop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= '0;
      discard_cnt_q  <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      discard_cnt_q  <= discard_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign discard_cnt  = discard_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: behavioural in-order memory plus a PC
// scoreboard, redirect vector table and hand-written corner sequences.
module tb_fetch_redirect_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_flush;
  logic [31:0] branch_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt;
  logic [31:0] discard_cnt;
`endif

  always #5 clk = ~clk;

  fetch_redirect_unit #(.RESET_PC(TB_RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_flush (branch_flush),
    .branch_pc    (branch_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .id_ready     (id_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .redirect_cnt (redirect_cnt),
    .discard_cnt  (discard_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_ent_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
  } redir_vec_t;

  mem_ent_t    mem_q[$];
  logic [31:0] exp_q[$];
  redir_vec_t  vecs[6];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_lat = 1;
  int flush_total = 0;

  logic        s_req, s_ifv, s_hs, s_grant;
  logic [31:0] s_addr, s_ifpc, s_instr;
  logic [31:0] held_pc, held_instr;
  int          n_wait;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic flush, input logic [31:0] pc, input logic gnt, input logic ready);
    branch_flush = flush;
    branch_pc    = pc;
    imem_gnt     = gnt;
    id_ready     = ready;
  endtask

  // One clock: sample at negedge, update scoreboard and memory, then drive
  // the memory response for the next cycle just after the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_ifv   = if_valid;
    s_ifpc  = if_pc;
    s_instr = if_instr;
    s_hs    = if_valid & id_ready;
    s_grant = imem_req & imem_gnt;
    if (s_hs) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_instr: got pc %h expected none", if_pc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_if_pc", if_pc, e);
        checkOutput("sb_if_instr", if_instr, memWord(e));
      end
    end
    if (branch_flush) begin
      checkOutput("flush_kills_if_valid", {31'b0, if_valid}, 32'd0);
      exp_q.delete();
      flush_total++;
    end
    if (s_grant) begin
      exp_q.push_back(imem_addr);
      mem_q.push_back('{addr: imem_addr, due: cyc + mem_lat});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic waitHandshake(output int n);
    n = 0;
    s_hs = 1'b0;
    while (!s_hs && n < 40) begin
      tick();
      n++;
    end
    if (!s_hs) begin
      checks++;
      failures++;
      $display("[TB] FAIL handshake_timeout: got none expected one within 40 cycles");
    end
  endtask

  task automatic waitPc(input string name, input logic [31:0] exp);
    int n;
    waitHandshake(n);
    if (s_hs) checkOutput(name, s_ifpc, exp);
  endtask

  initial begin
    rst_n        = 1'b0;
    branch_flush = 1'b0;
    branch_pc    = 32'h0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    id_ready     = 1'b0;

    vecs[0] = '{target: 32'h0000_0100, exp_addr: 32'h0000_0100};
    vecs[1] = '{target: 32'h0000_0103, exp_addr: 32'h0000_0100};
    vecs[2] = '{target: 32'h0000_2002, exp_addr: 32'h0000_2000};
    vecs[3] = '{target: 32'h8000_0001, exp_addr: 32'h8000_0000};
    vecs[4] = '{target: 32'h0000_0007, exp_addr: 32'h0000_0004};
    vecs[5] = '{target: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("reset_if_valid", {31'b0, if_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("reset_redirect_cnt", redirect_cnt, 32'd0);
    checkOutput("reset_discard_cnt", discard_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // Boot cycle, then back-to-back fetch with 2-cycle gnt-to-valid latency
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("boot_no_req", {31'b0, s_req}, 32'd0);
    tick();
    checkOutput("first_req", {31'b0, s_req}, 32'd1);
    checkOutput("first_addr", s_addr, TB_RESET_PC);
    tick();
    checkOutput("second_addr", s_addr, TB_RESET_PC + 32'd4);
    checkOutput("no_valid_yet", {31'b0, s_ifv}, 32'd0);
    tick();
    checkOutput("third_addr", s_addr, TB_RESET_PC + 32'd8);
    checkOutput("first_valid", {31'b0, s_ifv}, 32'd1);
    checkOutput("first_if_pc", s_ifpc, TB_RESET_PC);
    tick();
    checkOutput("stream_if_pc", s_ifpc, TB_RESET_PC + 32'd4);

    // Decode stall: output held, requests stop once credits are used up
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    held_pc    = s_ifpc;
    held_instr = s_instr;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("stall_if_pc_stable", s_ifpc, held_pc);
      checkOutput("stall_if_instr_stable", s_instr, held_instr);
      checkOutput("stall_if_valid", {31'b0, s_ifv}, 32'd1);
    end
    checkOutput("stall_req_low", {31'b0, s_req}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (4) tick();

    // Redirect with two-cycle memory so responses are in flight
    mem_lat = 2;
    repeat (6) tick();
    applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    tick();
    checkOutput("redirect_addr", s_addr, 32'h0000_0100);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    waitPc("redirect_first_pc", 32'h0000_0100);
    waitPc("redirect_second_pc", 32'h0000_0104);

    // Flush coinciding with rvalid and gnt: new-path grant is delivered
    mem_lat = 1;
    repeat (6) tick();
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    tick();
    checkOutput("coinc_req", {31'b0, s_req}, 32'd1);
    checkOutput("coinc_addr", s_addr, 32'h0000_0200);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    waitHandshake(n_wait);
    checkOutput("coinc_if_pc", s_ifpc, 32'h0000_0200);
    checkOutput("coinc_latency", n_wait, 32'd2);

    // Redirect vector table: alignment of branch targets
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].target, 1'b1, 1'b1);
      tick();
      checkOutput("vec_redirect_addr", s_addr, vecs[i].exp_addr);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      waitPc("vec_first_pc", vecs[i].exp_addr);
    end

    // PC wrap from the top of the address space
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (6) tick();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    tick();
    checkOutput("wrap_req", {31'b0, s_req}, 32'd1);
    checkOutput("wrap_addr", s_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("wrap_next_addr", s_addr, 32'h0000_0000);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    waitPc("wrap_pc_top", 32'hFFFF_FFFC);
    waitPc("wrap_pc_zero", 32'h0000_0000);

    // Random soak against the scoreboard
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) mem_lat = int'($urandom_range(1, 2));
      applyStimulus($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (8) tick();
    checkOutput("soak_nothing_lost", exp_q.size(), 32'd0);
    checkOutput("soak_idle_valid", {31'b0, s_ifv}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("redirect_cnt", redirect_cnt, flush_total);
`endif

    // Asynchronous reset in the middle of a drain
    mem_lat = 2;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (5) tick();
    applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_req", {31'b0, imem_req}, 32'd0);
    checkOutput("midreset_if_valid", {31'b0, if_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("midreset_redirect_cnt", redirect_cnt, 32'd0);
    checkOutput("midreset_discard_cnt", discard_cnt, 32'd0);
`endif
    exp_q.delete();
    mem_q.delete();
    imem_rvalid = 1'b0;
    mem_lat = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("restart_boot_no_req", {31'b0, s_req}, 32'd0);
    tick();
    checkOutput("restart_req", {31'b0, s_req}, 32'd1);
    checkOutput("restart_addr", s_addr, TB_RESET_PC);
    waitPc("restart_first_pc", TB_RESET_PC);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (6) tick();
    checkOutput("final_nothing_lost", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
